// File: rtl/multicycle_fsm_pkg.sv
// Shared types and encodings for the multicycle RV32I-subset sequencer.
// Imported by multicycle_fsm and alu_decoder.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_READ   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src_of(input logic [6:0] opcode);
        case (opcode)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_fsm_alu_decoder.sv
// Combinational ALU operation decoder; also flags opcodes and funct3
// values that the core does not implement.
module alu_decoder
    import mc_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [2:0] alu_control,
    output logic       unsupported
);

    always_comb begin
        alu_control = ALU_ADD;
        unsupported = 1'b0;
        case (opcode)
            OP_LW, OP_SW, OP_JAL: alu_control = ALU_ADD;
            OP_BEQ: begin
                alu_control = ALU_SUB;
                unsupported = (funct3 != 3'b000);
            end
            OP_R, OP_I: begin
                case (funct3)
                    // opcode[5] separates R-type from I-type: addi never subtracts
                    3'b000:  alu_control = (opcode[5] && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: unsupported = 1'b1;
                endcase
            end
            default: unsupported = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_fsm.sv
// Multicycle core main sequencer: Moore FSM with memory-ready handshake.
// Define MULTICYCLE_FSM_PERF_EN to add cycle / instret performance counters.
module multicycle_fsm
    import mc_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic [31:0]        i_instr,
    input  logic               i_zero,
    input  logic               i_mem_ready,
    output logic               o_PCWrite,
    output logic               o_AdrSrc,
    output logic               o_MemWrite,
    output logic               o_IRWrite,
    output logic               o_RegWrite,
    output logic [1:0]         o_ResultSrc,
    output logic [1:0]         o_ALUSrcA,
    output logic [1:0]         o_ALUSrcB,
    output logic [2:0]         o_ALUControl,
    output logic [1:0]         o_ImmSrc,
    output logic               o_illegal,
`ifdef MULTICYCLE_FSM_PERF_EN
    output logic [31:0]        o_cycle_cnt,
    output logic [31:0]        o_instret_cnt,
`endif
    output logic [STATE_W-1:0] o_state
);

    state_t     state;
    state_t     state_next;
    logic [6:0] opcode;
    logic [2:0] dec_alu;
    logic       dec_unsupported;
    logic       pc_write;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       unused_instr_bits;

    assign opcode            = i_instr[6:0];
    assign unused_instr_bits = ^{i_instr[31], i_instr[29:15], i_instr[11:7]};

    alu_decoder u_alu_decoder (
        .opcode      (opcode),
        .funct3      (i_instr[14:12]),
        .funct7_5    (i_instr[30]),
        .alu_control (dec_alu),
        .unsupported (dec_unsupported)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state <= S_FETCH;
        else         state <= state_next;
    end

    always_comb begin
        state_next   = state;
        pc_write     = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        o_AdrSrc     = 1'b0;
        o_ResultSrc  = RES_ALUOUT;
        o_ALUSrcA    = SRCA_PC;
        o_ALUSrcB    = SRCB_RS2;
        o_ALUControl = ALU_ADD;
        case (state)
            S_FETCH: begin
                o_ALUSrcB   = SRCB_FOUR;
                o_ResultSrc = RES_ALU;
                ir_write    = i_mem_ready;
                pc_write    = i_mem_ready;
                if (i_mem_ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                o_ALUSrcA = SRCA_OLDPC;
                o_ALUSrcB = SRCB_IMM;
                if (dec_unsupported) state_next = S_ILLEGAL;
                else begin
                    case (opcode)
                        OP_LW, OP_SW: state_next = S_MEMADR;
                        OP_R:         state_next = S_EXECUTER;
                        OP_I:         state_next = S_EXECUTEI;
                        OP_BEQ:       state_next = S_BEQ;
                        OP_JAL:       state_next = S_JAL;
                        default:      state_next = S_ILLEGAL;
                    endcase
                end
            end
            S_MEMADR: begin
                o_ALUSrcA  = SRCA_RS1;
                o_ALUSrcB  = SRCB_IMM;
                state_next = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                o_AdrSrc = 1'b1;
                if (i_mem_ready) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                o_ResultSrc = RES_READ;
                reg_write   = 1'b1;
                state_next  = S_FETCH;
            end
            S_MEMWRITE: begin
                o_AdrSrc  = 1'b1;
                mem_write = i_mem_ready;
                if (i_mem_ready) state_next = S_FETCH;
            end
            S_EXECUTER: begin
                o_ALUSrcA    = SRCA_RS1;
                o_ALUControl = dec_alu;
                state_next   = S_ALUWB;
            end
            S_EXECUTEI: begin
                o_ALUSrcA    = SRCA_RS1;
                o_ALUSrcB    = SRCB_IMM;
                o_ALUControl = dec_alu;
                state_next   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_BEQ: begin
                o_ALUSrcA    = SRCA_RS1;
                o_ALUControl = ALU_SUB;
                pc_write     = i_zero;
                state_next   = S_FETCH;
            end
            S_JAL: begin
                o_ALUSrcA  = SRCA_OLDPC;
                o_ALUSrcB  = SRCB_FOUR;
                pc_write   = 1'b1;
                state_next = S_ALUWB;
            end
            S_ILLEGAL: state_next = S_ILLEGAL;
            default:   state_next = S_FETCH;
        endcase
    end

    // Strobes are masked by reset directly so an asserting edge kills them combinationally.
    assign o_PCWrite  = pc_write  & i_rstn;
    assign o_MemWrite = mem_write & i_rstn;
    assign o_IRWrite  = ir_write  & i_rstn;
    assign o_RegWrite = reg_write & i_rstn;

    assign o_ImmSrc  = imm_src_of(opcode);
    assign o_illegal = (state == S_ILLEGAL);
    assign o_state   = STATE_W'(state);

`ifdef MULTICYCLE_FSM_PERF_EN
    logic retire;

    assign retire = (state_next == S_FETCH) &&
                    ((state == S_MEMWB) || (state == S_MEMWRITE) ||
                     (state == S_ALUWB) || (state == S_BEQ));

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_cycle_cnt   <= '0;
            o_instret_cnt <= '0;
        end else if (state != S_ILLEGAL) begin
            o_cycle_cnt <= o_cycle_cnt + 32'd1;
            if (retire) o_instret_cnt <= o_instret_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_fsm.sv
// Self-checking bench for multicycle_fsm: per-cycle control vector compared
// against an instruction-level timeline model with randomized wait states.
module tb_multicycle_fsm;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] instr = '0;
    logic        zero = 1'b0;
    logic        ready = 1'b0;
    logic        pcw, adr, memw, irw, regw, illegal;
    logic [1:0]  res, srca, srcb, imm;
    logic [2:0]  alu;
    logic [3:0]  state;
`ifdef MULTICYCLE_FSM_PERF_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    int ntests = 0;
    int nfail  = 0;

    logic [13:0] exp_q[$];
    bit          rdy_q[$];

    always #5 clk = ~clk;

    multicycle_fsm #(.STATE_W(4)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_instr(instr), .i_zero(zero),
        .i_mem_ready(ready), .o_PCWrite(pcw), .o_AdrSrc(adr), .o_MemWrite(memw),
        .o_IRWrite(irw), .o_RegWrite(regw), .o_ResultSrc(res), .o_ALUSrcA(srca),
        .o_ALUSrcB(srcb), .o_ALUControl(alu), .o_ImmSrc(imm), .o_illegal(illegal),
`ifdef MULTICYCLE_FSM_PERF_EN
        .o_cycle_cnt(cycle_cnt), .o_instret_cnt(instret_cnt),
`endif
        .o_state(state)
    );

    wire [13:0] obs = {pcw, irw, memw, regw, adr, res, srca, srcb, alu};

    function automatic logic [13:0] pk(input bit p, i, m, r, a, input logic [1:0] rs, sa, sb,
                                       input logic [2:0] op);
        return {p, i, m, r, a, rs, sa, sb, op};
    endfunction

    function automatic logic [2:0] exp_alu(input logic [31:0] ins);
        logic [2:0] f3;
        f3 = ins[14:12];
        if (f3 == 3'b010) return 3'b101;
        if (f3 == 3'b110) return 3'b011;
        if (f3 == 3'b111) return 3'b010;
        return (ins[6:0] == RT && ins[30]) ? 3'b001 : 3'b000;
    endfunction

    function automatic logic [1:0] exp_imm(input logic [6:0] op);
        if (op == SW) return 2'b01;
        if (op == BR) return 2'b10;
        if (op == JL) return 2'b11;
        return 2'b00;
    endfunction

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    // Expected per-cycle timeline of one instruction: (ready to drive, control vector).
    task automatic build(input logic [31:0] ins, input int wf, input int wd, input bit z);
        logic [13:0] idle;
        idle = pk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000);
        exp_q.delete();
        rdy_q.delete();
        for (int i = 0; i < wf; i++) begin
            rdy_q.push_back(1'b0); exp_q.push_back(pk(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000));
        end
        rdy_q.push_back(1'b1); exp_q.push_back(pk(1, 1, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000));
        rdy_q.push_back(rb()); exp_q.push_back(pk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000));
        case (ins[6:0])
            LW, SW: begin
                rdy_q.push_back(rb()); exp_q.push_back(pk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000));
                for (int i = 0; i < wd; i++) begin
                    rdy_q.push_back(1'b0); exp_q.push_back(pk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000));
                end
                rdy_q.push_back(1'b1);
                exp_q.push_back(pk(0, 0, ins[6:0] == SW, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000));
                if (ins[6:0] == LW) begin
                    rdy_q.push_back(rb()); exp_q.push_back(pk(0, 0, 0, 1, 0, 2'b01, 2'b00, 2'b00, 3'b000));
                end
            end
            RT, IT: begin
                rdy_q.push_back(rb());
                exp_q.push_back(pk(0, 0, 0, 0, 0, 2'b00, 2'b10, (ins[6:0] == IT) ? 2'b01 : 2'b00, exp_alu(ins)));
                rdy_q.push_back(rb()); exp_q.push_back(pk(0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000));
            end
            BR: begin
                rdy_q.push_back(rb()); exp_q.push_back(pk(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001));
            end
            JL: begin
                rdy_q.push_back(rb()); exp_q.push_back(pk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000));
                rdy_q.push_back(rb()); exp_q.push_back(pk(0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000));
            end
            default: begin
                rdy_q.push_back(rb()); exp_q.push_back(idle);
            end
        endcase
    endtask

    // Entered just after a falling edge; leaves just after a falling edge.
    task automatic run_instr(input logic [31:0] ins, input int wf, input int wd, input bit z);
        build(ins, wf, wd, z);
        for (int k = 0; k < exp_q.size(); k++) begin
            instr = ins;
            zero  = z;
            ready = rdy_q[k];
            #1;
            if (k == 0) begin
                ntests++;
                if (state !== 4'd0) begin
                    nfail++;
                    $display("FAIL start_in_fetch instr=%h state=%0d expected=0", ins, state);
                end
            end
            ntests++;
            if (obs !== exp_q[k]) begin
                nfail++;
                $display("FAIL ctrl_vector instr=%h cycle=%0d got=%b expected=%b", ins, k, obs, exp_q[k]);
            end
            if (k == wf + 1) begin
                ntests++;
                if (imm !== exp_imm(ins[6:0])) begin
                    nfail++;
                    $display("FAIL imm_src instr=%h got=%b expected=%b", ins, imm, exp_imm(ins[6:0]));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic check_fetch(input string tag);
        #1;
        ntests++;
        if (state !== 4'd0) begin
            nfail++;
            $display("FAIL %s state=%0d expected=0", tag, state);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn  = 1'b0;
        ready = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn  = 1'b0;
        ready = 1'b1;
        instr = 32'h002081B3;
        @(negedge clk);
        #1;
        ntests++;
        if (state !== 4'd0 || illegal !== 1'b0 || {pcw, irw, memw, regw} !== 4'b0000) begin
            nfail++;
            $display("FAIL reset_state state=%0d illegal=%b strobes=%b expected 0/0/0000",
                     state, illegal, {pcw, irw, memw, regw});
        end
        ready = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_rtype();
        run_instr(32'h002081B3, 0, 0, 1'b0);
        run_instr(32'h402081B3, 0, 0, 1'b0);
        run_instr(32'h0020E1B3, 1, 0, 1'b0);
        run_instr(32'h0020A1B3, 0, 0, 1'b1);
    endtask

    task automatic test_itype();
        run_instr(32'h40008093, 0, 0, 1'b0);
        run_instr(32'h0FF0F093, 0, 0, 1'b0);
        run_instr(32'hFFF0A093, 2, 0, 1'b0);
    endtask

    task automatic test_mem();
        run_instr(32'h0000A183, 0, 2, 1'b0);
        run_instr(32'h0020A023, 0, 0, 1'b0);
        run_instr(32'h0020A223, 1, 3, 1'b1);
    endtask

    task automatic test_branch_jump();
        run_instr(32'h00208463, 0, 0, 1'b1);
        run_instr(32'h00208463, 0, 0, 1'b0);
        run_instr(32'h008000EF, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] ins;
        logic [2:0]  f3;
        logic [4:0]  rd, rs1, rs2;
        for (int n = 0; n < 60; n++) begin
            rd  = 5'($urandom);
            rs1 = 5'($urandom);
            rs2 = 5'($urandom);
            case ($urandom_range(0, 3))
                0: f3 = 3'b000;
                1: f3 = 3'b010;
                2: f3 = 3'b110;
                default: f3 = 3'b111;
            endcase
            case ($urandom_range(0, 5))
                0: ins = {1'b0, (f3 == 3'b000) ? rb() : 1'b0, 5'd0, rs2, rs1, f3, rd, RT};
                1: ins = {12'($urandom), rs1, f3, rd, IT};
                2: ins = {12'($urandom), rs1, 3'b010, rd, LW};
                3: ins = {7'($urandom), rs2, rs1, 3'b010, 5'($urandom), SW};
                4: ins = {7'($urandom), rs2, rs1, 3'b000, 5'($urandom), BR};
                default: ins = {20'($urandom), rd, JL};
            endcase
            run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 3), rb());
        end
        check_fetch("random_end_fetch");
    endtask

    task automatic test_reset_midwrite();
        instr = 32'h0020A023;
        zero  = 1'b0;
        ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        ntests++;
        if (memw !== 1'b1) begin
            nfail++;
            $display("FAIL memwrite_before_reset got=%b expected=1", memw);
        end
        #1 rstn = 1'b0;
        #1;
        ntests++;
        if (memw !== 1'b0 || state !== 4'd0) begin
            nfail++;
            $display("FAIL memwrite_at_reset memw=%b state=%0d expected 0/0", memw, state);
        end
        @(negedge clk);
        ready = 1'b0;
        rstn  = 1'b1;
        check_fetch("after_reset_release");
        check_fetch("after_reset_hold");
    endtask

    task automatic test_illegal();
        logic [31:0] bad[4];
        bad = '{32'h0000007F, 32'h002091B3, 32'h00209463, 32'h0020D093};
        for (int b = 0; b < 4; b++) begin
            do_reset();
            build(bad[b], 0, 0, 1'b0);
            for (int k = 0; k < 2; k++) begin
                instr = bad[b];
                ready = 1'b1;
                #1;
                ntests++;
                if (obs !== exp_q[k]) begin
                    nfail++;
                    $display("FAIL illegal_prefix instr=%h cycle=%0d got=%b expected=%b", bad[b], k, obs, exp_q[k]);
                end
                @(negedge clk);
            end
            for (int k = 0; k < ((b == 0) ? 20 : 5); k++) begin
                ready = rb();
                zero  = rb();
                #1;
                ntests++;
                if (illegal !== 1'b1 || obs !== 14'd0) begin
                    nfail++;
                    $display("FAIL illegal_hold instr=%h cycle=%0d illegal=%b ctrl=%b expected 1/0",
                             bad[b], k, illegal, obs);
                end
                @(negedge clk);
            end
        end
        rstn = 1'b0;
        #1;
        ntests++;
        if (illegal !== 1'b0 || state !== 4'd0) begin
            nfail++;
            $display("FAIL illegal_cleared illegal=%b state=%0d expected 0/0", illegal, state);
        end
        ready = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

`ifdef MULTICYCLE_FSM_PERF_EN
    task automatic test_perf();
        do_reset();
        for (int n = 0; n < 3; n++) run_instr(32'h002081B3, 0, 0, 1'b0);
        #1;
        ntests++;
        if (cycle_cnt !== 32'd12 || instret_cnt !== 32'd3) begin
            nfail++;
            $display("FAIL perf_counts cycle=%0d instret=%0d expected 12/3", cycle_cnt, instret_cnt);
        end
        instr = 32'h0000007F;
        ready = 1'b1;
        repeat (22) @(negedge clk);
        #1;
        ntests++;
        if (cycle_cnt !== 32'd14 || instret_cnt !== 32'd3) begin
            nfail++;
            $display("FAIL perf_freeze cycle=%0d instret=%0d expected 14/3", cycle_cnt, instret_cnt);
        end
        do_reset();
        #1;
        ntests++;
        if (cycle_cnt !== 32'd0 || instret_cnt !== 32'd0) begin
            nfail++;
            $display("FAIL perf_reset cycle=%0d instret=%0d expected 0/0", cycle_cnt, instret_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_rtype();
        test_itype();
        test_mem();
        test_branch_jump();
        test_random();
        test_reset_midwrite();
        test_illegal();
`ifdef MULTICYCLE_FSM_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/multicycle_fsm.md
Name: multicycle_fsm

Overview:
- Main sequencer for the multicycle RV32I-subset core. It drives every enable and mux select of the shared datapath: PC register, instruction register, unified memory, register file, ALU and immediate extender.
- Moore FSM plus a combinational ALU decoder. Adds a memory-ready handshake so memory accesses can take wait states.
- Supported instructions: lw, sw, R-type (add/sub/slt/or/and), I-type ALU (addi/slti/ori/andi), beq, jal.

Parameters:
- STATE_W, 4, width of the state encoding exported on o_state.

Ports:
- i_clk  in  1  core clock
- i_rstn  in  1  reset, asynchronous, active-low
- i_instr  in  32  instruction-register output (opcode, funct3, funct7[5] used)
- i_zero  in  1  ALU zero flag
- i_mem_ready  in  1  memory completes the current access this cycle
- o_PCWrite  out  1  PC register enable
- o_AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- o_MemWrite  out  1  memory write strobe
- o_IRWrite  out  1  instruction register and old-PC register enable
- o_RegWrite  out  1  register-file write enable
- o_ResultSrc  out  2  00 = ALUOut, 01 = read data, 10 = ALU result
- o_ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1 register
- o_ALUSrcB  out  2  00 = rs2 register, 01 = ImmExt, 10 = constant 4
- o_ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- o_ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- o_state  out  STATE_W  current state, for debug
- o_illegal  out  1  sticky illegal-instruction flag

Behaviour:
- Reset: state = FETCH (code 0), o_illegal = 0. While i_rstn is low, all write strobes (PCWrite, MemWrite, IRWrite, RegWrite) are forced to 0.
- Reset asserted mid-instruction aborts the instruction immediately; there are no partial writes after the asserting edge.
- Outputs are decoded from the state only, except:
  - memory-gated strobes are qualified by i_mem_ready;
  - o_ALUControl and o_ImmSrc are also decoded from i_instr.
- Unlisted selects default to 00 and unlisted strobes to 0 in every state.
- States and transitions:
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUControl add, ResultSrc=10.
    - IRWrite = PCWrite = i_mem_ready.
    - Stays in FETCH while !i_mem_ready, otherwise goes to DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, add (branch target). Next state by opcode:
    - 0000011 / 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - any other opcode, or an unsupported funct3 (001, 011, 100, 101, or 000 on a branch is the only branch funct3 supported) -> ILLEGAL
  - MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next state MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Holds until i_mem_ready, then MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
  - MEMWRITE: AdrSrc=1, MemWrite = i_mem_ready. Holds until i_mem_ready, then FETCH.
  - EXECUTER / EXECUTEI: ALUSrcA=10; ALUSrcB=00 (R) or 01 (I); then ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite = i_zero, then FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, then ALUWB.
  - ILLEGAL: terminal. o_illegal=1, no strobes, exits only on reset.
- ALU decode:
  - lw/sw/jal -> add; beq -> sub.
  - funct3 000 -> sub only when opcode[5] & funct7[5], otherwise add.
  - funct3 010 -> slt, 110 -> or, 111 -> and.
- Latency with zero wait states: lw 5, sw 4, R 4, I 4, beq 3, jal 4 cycles. Each wait cycle adds 1.

Optional Feature:
- Macro MULTICYCLE_FSM_PERF_EN adds two 32-bit outputs: o_cycle_cnt and o_instret_cnt.
- o_cycle_cnt increments every cycle out of reset.
- o_instret_cnt increments on each transition into FETCH from a final state.
- Both counters reset to 0, wrap modulo 2^32, and freeze in ILLEGAL.
- Without the macro the ports and logic are absent.

Decomposition:
- Package mc_pkg: state enum, opcode constants, ALU control codes, ResultSrc/ALUSrcA/ALUSrcB/ImmSrc encodings.
- Sub-module alu_decoder: combinational; inputs opcode, funct3, funct7[5]; outputs ALU control and unsupported flag.

Test Plan:
- Reset, then add x3,x1,x2 (0x002081B3) with ready=1 -> states FETCH, DECODE, EXECUTER, ALUWB; ALUControl=000; RegWrite=1 only in cycle 4. Repeat with 0x402081B3 -> ALUControl=001.
- lw x3,0(x1) (0x0000A183) with ready low for 2 cycles in MEMREAD -> MEMREAD held 3 cycles, AdrSrc=1; MEMWB has ResultSrc=01, RegWrite=1; 7 cycles total.
- beq x1,x2,8 (0x00208463): zero=1 -> PCWrite=1 in the BEQ cycle; zero=0 -> PCWrite=0; both return to FETCH.
- Opcode 0x0000007F -> ILLEGAL, o_illegal=1 and stays set, all strobes 0 for 20 cycles. Reset -> o_illegal=0, state FETCH.
- Reset pulsed while in MEMWRITE with ready=1 -> MemWrite=0 from the asserting edge, state = 0 after release.
- With MULTICYCLE_FSM_PERF_EN: 3 back-to-back R-type instructions from reset -> o_instret_cnt=3, o_cycle_cnt=12 at the third return to FETCH.
